// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   32-entry register file with two combinational read ports and one write
//   port. Entry 0 is hard-wired to zero. The storage array has no bulk reset
//   so it can map onto FPGA distributed RAM. Instead, after reset a CLEAR
//   state walks a counter through every entry and writes zero, one entry per
//   cycle. Once the walk completes the block enters READY and raises ready.
//
// Ports
//   clk    : sole clock, rising edge
//   reset  : synchronous active-high reset
//   A1/RD1 : read port 1 index / data (ALU a_in operand path)
//   A2/RD2 : read port 2 index / data (ALU b_in operand path)
//   A3     : write port index
//   WD3    : write data
//   WE3    : write enable (ignored during CLEAR and while reset is high)
//   ready  : high only in READY (clear sequence complete)
// ---------------------------------------------------------------------------
module register_file #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  input  logic [4:0]       A3,
  input  logic [WIDTH-1:0] WD3,
  input  logic             WE3,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  output logic             ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t           r_state;
  logic [4:0]       r_cnt;
  logic             r_ready;
  logic [WIDTH-1:0] r_mem [0:31];

  logic             w_clearing;
  logic             w_user_wr;
  logic             w_we;
  logic [4:0]       w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_rd_ok;

  // Control FSM. The counter wraps from 31 to 0 naturally on the step
  // that moves the block into READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CLEAR;
      r_cnt   <= 5'd0;
      r_ready <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) begin
        r_state <= READY;
        r_ready <= 1'b1;
      end
    end
  end

  assign ready = r_ready;

  // Single write port shared by the clear walk and user writes, so the array
  // keeps the one-write-port shape distributed RAM expects. User writes in
  // CLEAR are dropped outright, never queued.
  assign w_clearing = (r_state == CLEAR);
  assign w_user_wr  = (r_state == READY) && WE3 && (A3 != 5'd0);
  assign w_we       = !reset && (w_clearing || w_user_wr);
  assign w_waddr    = w_clearing ? r_cnt : A3;
  assign w_wdata    = w_clearing ? '0 : WD3;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Reads are forced to zero until the array has been cleared and while
  // reset is asserted, since array contents are meaningless then.
  assign w_rd_ok = r_ready && !reset;

  // Write-first bypass: a same-cycle write to the read index is forwarded.
  // Both ports use identical logic, so A1==A2 always yields equal data.
  always_comb begin
    RD1 = '0;
    if (w_rd_ok && (A1 != 5'd0)) begin
      if (w_user_wr && (A3 == A1)) RD1 = WD3;
      else                         RD1 = r_mem[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (w_rd_ok && (A2 != 5'd0)) begin
      if (w_user_wr && (A3 == A2)) RD2 = WD3;
      else                         RD2 = r_mem[A2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed stimulus for register_file. The driver presents one input vector
//   per cycle (shortly after the rising edge) and pushes the hand-computed
//   expected RD1/RD2/ready for that cycle into a queue tagged with the cycle
//   number. A monitor on the falling edge pops entries due for the current
//   cycle and compares them against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] RD1, RD2;
  logic        ready;

  register_file #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .A1    (A1),
    .A2    (A2),
    .A3    (A3),
    .WD3   (WD3),
    .WE3   (WE3),
    .RD1   (RD1),
    .RD2   (RD2),
    .ready (ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Monitor: compare every expectation tagged for the current cycle. Any
  // entry tagged for an earlier cycle was missed and counts as a failure.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      if (e.cyc < cyc) begin
        n_total++;
        $display("FAIL %s: expectation for cycle %0d not compared, now cycle %0d", e.name, e.cyc, cyc);
      end else begin
        check({e.name, ".RD1"},   RD1,           e.rd1);
        check({e.name, ".RD2"},   RD2,           e.rd2);
        check({e.name, ".ready"}, {31'd0, ready}, {31'd0, e.rdy});
      end
    end
  end

  // Present one vector for the coming cycle.
  task automatic drive(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd, input logic we);
    @(posedge clk);
    #1;
    reset = rst;
    A1 = a1; A2 = a2; A3 = a3; WD3 = wd; WE3 = we;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] r1, input logic [31:0] r2,
                            input logic rdy);
    exp_t e;
    e.name = nm; e.cyc = cyc; e.rd1 = r1; e.rd2 = r2; e.rdy = rdy;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; A1 = 5'd0; A2 = 5'd0; A3 = 5'd0; WD3 = 32'd0; WE3 = 1'b0;

    // Reset held for 3 cycles: outputs quiet.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd5, 5'd3, 5'd0, 32'd0, 1'b0);
      expect_out("in_reset", 32'd0, 32'd0, 1'b0);
    end

    // Release: ready low for 32 cycles, high on the 33rd. A write to x7 at
    // cycle 10 of CLEAR must be discarded.
    for (int i = 0; i <= 32; i++) begin
      if (i == 10) drive(1'b0, 5'd7, 5'd7, 5'd7, 32'h1234, 1'b1);
      else         drive(1'b0, 5'd7, i[4:0], 5'd0, 32'd0, 1'b0);
      expect_out($sformatf("clear_%0d", i), 32'd0, 32'd0, (i == 32));
    end

    // Every index reads zero once ready.
    for (int j = 0; j < 32; j++) begin
      drive(1'b0, j[4:0], 5'(31 - j), 5'd0, 32'd0, 1'b0);
      expect_out($sformatf("zero_x%0d", j), 32'd0, 32'd0, 1'b1);
    end

    // Write x5 with same-cycle bypass, then a plain read.
    drive(1'b0, 5'd5, 5'd4, 5'd5, 32'h0000002A, 1'b1);
    expect_out("wr_x5_bypass", 32'h2A, 32'd0, 1'b1);
    drive(1'b0, 5'd5, 5'd5, 5'd0, 32'd0, 1'b0);
    expect_out("rd_x5", 32'h2A, 32'h2A, 1'b1);

    // Writes to x0 are discarded, including on the bypass path.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    expect_out("wr_x0", 32'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    expect_out("rd_x0", 32'd0, 32'd0, 1'b1);

    // x9=1, then overwrite with both ports bypassing.
    drive(1'b0, 5'd0, 5'd0, 5'd9, 32'h1, 1'b1);
    expect_out("wr_x9_old", 32'd0, 32'd0, 1'b1);
    drive(1'b0, 5'd9, 5'd9, 5'd9, 32'hABCD, 1'b1);
    expect_out("wr_x9_bypass", 32'hABCD, 32'hABCD, 1'b1);
    drive(1'b0, 5'd9, 5'd9, 5'd0, 32'd0, 1'b0);
    expect_out("rd_x9", 32'hABCD, 32'hABCD, 1'b1);

    // Bypass only on the matching port.
    drive(1'b0, 5'd9, 5'd10, 5'd10, 32'h55, 1'b1);
    expect_out("bypass_port2_only", 32'hABCD, 32'h55, 1'b1);
    drive(1'b0, 5'd10, 5'd5, 5'd0, 32'd0, 1'b0);
    expect_out("rd_x10_x5", 32'h55, 32'h2A, 1'b1);

    // x3=0x11, one-cycle reset, then the full clear runs again.
    drive(1'b0, 5'd3, 5'd0, 5'd3, 32'h11, 1'b1);
    expect_out("wr_x3_bypass", 32'h11, 32'd0, 1'b1);
    drive(1'b1, 5'd3, 5'd5, 5'd0, 32'd0, 1'b0);
    expect_out("reset_in_ready", 32'd0, 32'd0, 1'b1);
    for (int i = 0; i <= 32; i++) begin
      drive(1'b0, 5'd3, 5'd5, 5'd0, 32'd0, 1'b0);
      expect_out($sformatf("reclear_%0d", i), 32'd0, 32'd0, (i == 32));
    end
    drive(1'b0, 5'd9, 5'd10, 5'd0, 32'd0, 1'b0);
    expect_out("after_reclear", 32'd0, 32'd0, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH SHALL default to 32 and set the data width of every data port and register.
REQ-002 Parameter DEPTH SHALL be fixed at 32 registers (x0..x31), addressed by 5-bit indices.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 A1  input  5  read port 1 register index; its data feeds the ALU a_in operand path.
REQ-006 A2  input  5  read port 2 register index; its data feeds the ALU b_in operand path.
REQ-007 RD1  output  WIDTH  read port 1 data.
REQ-008 RD2  output  WIDTH  read port 2 data.
REQ-009 A3  input  5  write port register index.
REQ-010 WD3  input  WIDTH  write data, typically ALUResult from the ALU.
REQ-011 WE3  input  1  write enable for the write port.
REQ-012 ready  output  1  high when the clear sequence is complete and the file accepts writes.

Function
REQ-013 The storage array SHALL be implemented without a bulk reset so that it maps to FPGA distributed RAM.
REQ-014 A two-state FSM, CLEAR and READY, SHALL control the block.
REQ-015 A 5-bit clear counter SHALL address the array during CLEAR.
REQ-016 In CLEAR, each cycle SHALL write 0 to array[counter] and increment the counter.
REQ-017 When the counter equals 31 in CLEAR, the next state SHALL be READY and the counter SHALL wrap to 0.
REQ-018 ready SHALL be high if and only if the state is READY.
REQ-019 In READY, the block SHALL write WD3 to array[A3] on the rising edge when WE3=1 and A3!=0.
REQ-020 Writes with A3=0 SHALL be discarded.
REQ-021 A write with WE3=1 in CLEAR SHALL be ignored, with no array update and no deferred write.
REQ-022 Reads SHALL be combinational from A1 and A2, with no added latency.
REQ-023 An index of 0 SHALL always read as 0.
REQ-024 In CLEAR, RD1 and RD2 SHALL read as 0 for every index.
REQ-025 Write-first bypass: in READY, when WE3=1, A3!=0 and A3==A1, RD1 SHALL equal WD3 in the same cycle; RD2 SHALL behave identically for A2.
REQ-026 When A1==A2, RD1 and RD2 SHALL return identical data, including under bypass.
REQ-027 A write to index k SHALL be visible on a non-bypassed read starting in the cycle after the write edge.

Reset
REQ-028 While reset=1, the state SHALL be CLEAR, the counter SHALL be 0, ready SHALL be 0, RD1/RD2 SHALL be 0, and no array write SHALL occur.
REQ-029 After reset deasserts at edge E0, array writes SHALL occur at edges E1..E32, and ready SHALL be high after E32.
REQ-030 From reset release, ready SHALL rise exactly 32 cycles later.
REQ-031 Reset asserted during CLEAR or READY SHALL restart the full clear sequence from counter 0 on release.
REQ-032 Array contents SHALL be treated as undefined until the first clear completes.

Verification
REQ-033 Reset held for 3 cycles, then released -> ready=0 for 32 cycles then 1; every index reads 0 after ready rises.
REQ-034 After ready: write A3=5, WD3=0x0000002A, WE3=1 -> RD1 (A1=5) shows 0x2A in the write cycle via bypass and 0x2A in later cycles with WE3=0.
REQ-035 Write A3=0, WD3=0xFFFFFFFF, WE3=1 -> RD1/RD2 with A1=A2=0 read 0 in the write cycle and afterwards.
REQ-036 WE3=1, A3=7, WD3=0x1234 at cycle 10 after release (CLEAR) -> x7 reads 0 after ready rises.
REQ-037 Write x3=0x11; assert reset 1 cycle; release -> ready=0 for 32 cycles, then x3 reads 0.
REQ-038 Same-cycle A1=A2=9, A3=9, WD3=0xABCD, WE3=1 with old x9=0x1 -> RD1=RD2=0xABCD; the next cycle with WE3=0 -> RD1=RD2=0xABCD.
